// File: rtl/rom_fetch_unit_pkg.sv
// Shared definitions for the program-ROM fetch unit: FSM state encoding and
// the opcode length decode shared with the instruction decoder.
package rom_fetch_unit_pkg;

  localparam int MAX_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    RD_OP1 = 2'd0,
    RD_OP2 = 2'd1,
    RD_ARG = 2'd2,
    HOLD   = 2'd3
  } fetch_state_t;

  // An opcode is two bytes long when its flag bit is set.
  function automatic logic instr_has_operand(input logic [MAX_DATA_WIDTH-1:0] opcode,
                                             input logic [4:0] flag_bit);
    return opcode[flag_bit];
  endfunction

endpackage

// File: rtl/rom_fetch_unit.sv
// Fetch unit for the registered-read program ROM: pipelines the address bus,
// assembles 1- or 2-byte instructions and hands them over on valid/ready.
module rom_fetch_unit
  import rom_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int OPERAND_FLAG_BIT = 7
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [DATA_WIDTH-1:0] INSTR_OPCODE,
  output logic [DATA_WIDTH-1:0] INSTR_OPERAND,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  input  logic                  JUMP_EN,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR
);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [ADDR_WIDTH-1:0] rom_addr_nxt;
  logic [ADDR_WIDTH-1:0] instr_addr_nxt;
  logic [DATA_WIDTH-1:0] opcode_nxt, operand_nxt;
  logic                  valid_nxt;
  logic                  has_operand;

  assign has_operand = instr_has_operand(MAX_DATA_WIDTH'(ROM_DATA), 5'(OPERAND_FLAG_BIT));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= RD_OP1;
      pc            <= RESET_VECTOR;
      ROM_ADDRESS   <= RESET_VECTOR;
      INSTR_VALID   <= 1'b0;
      INSTR_OPCODE  <= '0;
      INSTR_OPERAND <= '0;
      INSTR_ADDR    <= RESET_VECTOR;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      ROM_ADDRESS   <= rom_addr_nxt;
      INSTR_VALID   <= valid_nxt;
      INSTR_OPCODE  <= opcode_nxt;
      INSTR_OPERAND <= operand_nxt;
      INSTR_ADDR    <= instr_addr_nxt;
    end
  end

  // ROM data lags the address by one edge, so the address runs one byte
  // ahead of the byte being captured.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    rom_addr_nxt   = ROM_ADDRESS;
    valid_nxt      = INSTR_VALID;
    opcode_nxt     = INSTR_OPCODE;
    operand_nxt    = INSTR_OPERAND;
    instr_addr_nxt = INSTR_ADDR;

    case (state)
      RD_OP1: begin
        rom_addr_nxt = pc + ADDR_WIDTH'(1);
        state_nxt    = RD_OP2;
      end
      RD_OP2: begin
        opcode_nxt     = ROM_DATA;
        instr_addr_nxt = pc;
        if (!has_operand) begin
          operand_nxt = '0;
          pc_nxt      = pc + ADDR_WIDTH'(1);
          valid_nxt   = 1'b1;
          state_nxt   = HOLD;
        end else begin
          state_nxt = RD_ARG;
        end
      end
      RD_ARG: begin
        operand_nxt = ROM_DATA;
        pc_nxt      = pc + ADDR_WIDTH'(2);
        valid_nxt   = 1'b1;
        state_nxt   = HOLD;
      end
      HOLD: begin
        if (INSTR_READY) begin
          valid_nxt    = 1'b0;
          rom_addr_nxt = pc;
          state_nxt    = RD_OP1;
        end
      end
      default: state_nxt = RD_OP1;
    endcase

    // A jump overrides everything, including a transfer at the same edge.
    if (JUMP_EN) begin
      pc_nxt       = JUMP_ADDR;
      rom_addr_nxt = JUMP_ADDR;
      valid_nxt    = 1'b0;
      state_nxt    = RD_OP1;
    end
  end

endmodule
